acc_regfile: RTL and testbench

//  Operand/write-back stage around the ALU: holds the accumulator (ACC), a

---
 rtl/acc_regfile_if.sv | 26 ++
 rtl/acc_regfile.sv | 91 +++++++++
 tb/tb_acc_regfile.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_regfile_if.sv
// Operand/write-back bus between issue logic and acc_regfile.
// master drives instructions and ALU result; slave returns operands.
interface acc_regfile_if #(
  parameter int DWIDTH = 8,
  parameter int RADDR  = 3
);
  logic              en;
  logic [3:0]        instr;
  logic [RADDR-1:0]  addr;
  logic [DWIDTH-1:0] data;
  logic [DWIDTH-1:0] alu;
  logic [DWIDTH-1:0] a;
  logic [DWIDTH-1:0] b;
  logic              z;
  logic              busy;

  modport master (
    output en, instr, addr, data, alu,
    input  a, b, z, busy
  );

  modport slave (
    input  en, instr, addr, data, alu,
    output a, b, z, busy
  );
endinterface

// File: rtl/acc_regfile.sv
// Accumulator, register file and zero flag around the ALU,
// with a multi-cycle register clear sequence.
module acc_regfile #(
  parameter int DWIDTH = 8,
  parameter int RADDR  = 3
) (
  input logic          clk,
  input logic          rst_n,
  acc_regfile_if.slave bus
);
  localparam int NREG = 2 ** RADDR;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DWIDTH-1:0] acc;
  logic              zflag;
  logic [RADDR-1:0]  cnt;
  logic [DWIDTH-1:0] regs [NREG];

  logic is_alu;
  logic is_ld;
  logic is_st;
  logic is_rst;

  always_comb begin
    is_alu = 1'b0;
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_rst = 1'b0;
    unique case (1'b1)
      (bus.instr <= 4'd9):  is_alu = 1'b1;
      (bus.instr == 4'hA):  is_ld  = 1'b1;
      (bus.instr == 4'hB):  is_st  = 1'b1;
      (bus.instr == 4'hD):  is_rst = 1'b1;
      default: ;
    endcase
  end

  wire issue = bus.en && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (issue && is_rst) state_nxt = CLEAR;
      CLEAR:   if (cnt == RADDR'(NREG - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      zflag <= 1'b1;
      cnt   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
      cnt       <= cnt + 1'b1;
    end else if (issue) begin
      unique case (1'b1)
        (is_alu || is_ld): begin
          acc   <= bus.alu;
          zflag <= (bus.alu == '0);
        end
        is_st: regs[bus.addr] <= acc;
        is_rst: begin
          acc   <= '0;
          zflag <= 1'b1;
          cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Operand B reads the array directly, so a same-cycle ST is not forwarded.
  assign bus.b = is_ld ? bus.data : regs[bus.addr];
  assign bus.a = acc;
  assign bus.z = zflag;
endmodule

// File: tb/tb_acc_regfile.sv
// Directed self-checking bench for acc_regfile.
// Expected values are hand-computed per scenario.
module tb_acc_regfile;
  localparam int DW = 8;
  localparam int RA = 3;

  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_NOP = 4'hC;
  localparam logic [3:0] OP_RST = 4'hD;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  acc_regfile_if #(.DWIDTH(DW), .RADDR(RA)) bus ();

  acc_regfile #(.DWIDTH(DW), .RADDR(RA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] op,
                       input logic [RA-1:0] ad,
                       input logic [DW-1:0] dt,
                       input logic [DW-1:0] al);
    bus.en    = en;
    bus.instr = op;
    bus.addr  = ad;
    bus.data  = dt;
    bus.alu   = al;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [RA-1:0] ad,
                       input logic [DW-1:0] dt,
                       input logic [DW-1:0] al);
    drive(1'b1, op, ad, dt, al);
    tick();
    drive(1'b0, OP_NOP, '0, '0, '0);
  endtask

  task automatic load(input logic [DW-1:0] v);
    issue(OP_LD, '0, v, v);
  endtask

  task automatic fill_regs();
    for (int i = 0; i < 8; i++) begin
      load(DW'(8'h10 + i));
      issue(OP_ST, RA'(i), '0, '0);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, OP_NOP, '0, '0, '0);
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (bus.a !== 8'h00)
      $display("FAIL reset_a got %h want 00", bus.a);
    else pass_cnt++;
    total_cnt++;
    if (bus.z !== 1'b1)
      $display("FAIL reset_z got %b want 1", bus.z);
    else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL reset_busy got %b want 0", bus.busy);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, OP_ADD, RA'(i), '0, '0);
      #1;
      total_cnt++;
      if (bus.b !== 8'h00)
        $display("FAIL reset_b[%0d] got %h want 00", i, bus.b);
      else pass_cnt++;
    end
  endtask

  task automatic test_ld_st();
    load(8'h5A);
    total_cnt++;
    if (bus.a !== 8'h5A)
      $display("FAIL ld_a got %h want 5a", bus.a);
    else pass_cnt++;
    total_cnt++;
    if (bus.z !== 1'b0)
      $display("FAIL ld_z got %b want 0", bus.z);
    else pass_cnt++;
    drive(1'b1, OP_LD, 3'd0, 8'hC3, 8'h00);
    #1;
    total_cnt++;
    if (bus.b !== 8'hC3)
      $display("FAIL ld_bmux got %h want c3", bus.b);
    else pass_cnt++;
    drive(1'b0, OP_NOP, '0, '0, '0);
    issue(OP_ST, 3'd3, '0, '0);
    drive(1'b0, OP_ADD, 3'd3, '0, '0);
    #1;
    total_cnt++;
    if (bus.b !== 8'h5A)
      $display("FAIL st_b3 got %h want 5a", bus.b);
    else pass_cnt++;
  endtask

  task automatic test_add_zero();
    load(8'h01);
    issue(OP_ST, 3'd1, '0, '0);
    load(8'hFF);
    drive(1'b1, OP_ADD, 3'd1, '0, 8'h00);
    #1;
    total_cnt++;
    if (bus.b !== 8'h01)
      $display("FAIL add_b got %h want 01", bus.b);
    else pass_cnt++;
    tick();
    drive(1'b0, OP_NOP, '0, '0, '0);
    total_cnt++;
    if (bus.a !== 8'h00)
      $display("FAIL add_a got %h want 00", bus.a);
    else pass_cnt++;
    total_cnt++;
    if (bus.z !== 1'b1)
      $display("FAIL add_z got %b want 1", bus.z);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    load(8'h77);
    drive(1'b1, OP_ST, 3'd1, '0, '0);
    #1;
    total_cnt++;
    if (bus.b !== 8'h01)
      $display("FAIL rdw_old got %h want 01", bus.b);
    else pass_cnt++;
    tick();
    drive(1'b1, OP_ADD, 3'd1, '0, 8'h78);
    #1;
    total_cnt++;
    if (bus.b !== 8'h77)
      $display("FAIL rdw_new got %h want 77", bus.b);
    else pass_cnt++;
    tick();
    drive(1'b0, OP_NOP, '0, '0, '0);
    total_cnt++;
    if (bus.a !== 8'h78)
      $display("FAIL b2b_a got %h want 78", bus.a);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    int n;
    fill_regs();
    load(8'h99);
    issue(OP_RST, '0, '0, '0);
    total_cnt++;
    if (bus.a !== 8'h00)
      $display("FAIL clr_a got %h want 00", bus.a);
    else pass_cnt++;
    total_cnt++;
    if (bus.z !== 1'b1)
      $display("FAIL clr_z got %b want 1", bus.z);
    else pass_cnt++;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.busy) break;
      n++;
      if (k % 2 == 0) drive(1'b1, OP_LD, 3'd2, 8'hEE, 8'hEE);
      else            drive(1'b1, OP_ST, 3'd2, '0, '0);
      tick();
    end
    drive(1'b0, OP_NOP, '0, '0, '0);
    total_cnt++;
    if (n !== 8)
      $display("FAIL clr_busy_cycles got %0d want 8", n);
    else pass_cnt++;
    total_cnt++;
    if (bus.a !== 8'h00)
      $display("FAIL clr_ignored_a got %h want 00", bus.a);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, OP_ADD, RA'(i), '0, '0);
      #1;
      total_cnt++;
      if (bus.b !== 8'h00)
        $display("FAIL clr_b[%0d] got %h want 00", i, bus.b);
      else pass_cnt++;
    end
    drive(1'b0, OP_NOP, '0, '0, '0);
  endtask

  task automatic test_abort();
    fill_regs();
    load(8'h66);
    issue(OP_RST, '0, '0, '0);
    tick();
    tick();
    tick();
    total_cnt++;
    if (bus.busy !== 1'b1)
      $display("FAIL abort_busy_pre got %b want 1", bus.busy);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0)
      $display("FAIL abort_busy got %b want 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.a !== 8'h00)
      $display("FAIL abort_a got %h want 00", bus.a);
    else pass_cnt++;
    for (int i = 3; i < 8; i++) begin
      drive(1'b0, OP_ADD, RA'(i), '0, '0);
      #0.1;
      total_cnt++;
      if (bus.b !== 8'h00)
        $display("FAIL abort_b[%0d] got %h want 00", i, bus.b);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    drive(1'b0, OP_NOP, '0, '0, '0);
    tick();
    load(8'h42);
    total_cnt++;
    if (bus.a !== 8'h42 || bus.z !== 1'b0)
      $display("FAIL abort_ld got a=%h z=%b want a=42 z=0",
               bus.a, bus.z);
    else pass_cnt++;
  endtask

  task automatic test_en_low();
    issue(OP_ST, 3'd5, '0, '0);
    drive(1'b0, OP_ADD, 3'd5, '0, 8'h33);
    tick();
    tick();
    drive(1'b0, OP_ST, 3'd6, '0, 8'h33);
    tick();
    total_cnt++;
    if (bus.a !== 8'h42)
      $display("FAIL enlow_a got %h want 42", bus.a);
    else pass_cnt++;
    total_cnt++;
    if (bus.z !== 1'b0)
      $display("FAIL enlow_z got %b want 0", bus.z);
    else pass_cnt++;
    drive(1'b0, OP_ADD, 3'd5, '0, '0);
    #1;
    total_cnt++;
    if (bus.b !== 8'h42)
      $display("FAIL enlow_b5 got %h want 42", bus.b);
    else pass_cnt++;
    drive(1'b0, OP_ADD, 3'd6, '0, '0);
    #1;
    total_cnt++;
    if (bus.b !== 8'h00)
      $display("FAIL enlow_b6 got %h want 00", bus.b);
    else pass_cnt++;
    drive(1'b0, OP_NOP, '0, '0, '0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b1;
    drive(1'b0, OP_NOP, '0, '0, '0);
    #2;
    test_reset();
    test_ld_st();
    test_add_zero();
    test_back_to_back();
    test_clear();
    test_abort();
    test_en_low();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
